// File: rtl/ppu_requant_if.sv
// Bundle of the ppu_requant control inputs, accumulator row input and
// quantised row output. master drives the control/data side, slave is the PPU.
interface ppu_requant_if;
    logic [1:0]   i_mode;
    logic         i_mtrx_start;
    logic         i_calc;
    logic         i_tile_start;
    logic [383:0] i_acc_data;
    logic         o_valid;
    logic [3:0]   o_row;
    logic [127:0] o_data;
    logic [4:0]   o_shift;
    logic         o_busy;
    logic         o_overrun;

    modport master (
        output i_mode, i_mtrx_start, i_calc, i_tile_start, i_acc_data,
        input  o_valid, o_row, o_data, o_shift, o_busy, o_overrun
    );

    modport slave (
        input  i_mode, i_mtrx_start, i_calc, i_tile_start, i_acc_data,
        output o_valid, o_row, o_data, o_shift, o_busy, o_overrun
    );
endinterface

// File: rtl/ppu_requant.sv
// Post-processing requantiser: captures 16 rows of 16 x INT24 accumulators
// per tile, tracks the matrix-wide max |x| in MAX passes and emits rounded,
// saturated INT8/INT4 rows with their shift exponent in CALC passes.
// Two-stage pipeline: stage 1 = abs/max/shift, stage 2 = round/saturate.
// Optional feature: define PPU_RELU_EN to clamp every entry at zero first.
module ppu_requant (
    input  logic         i_clk,
    input  logic         i_rst,
    ppu_requant_if.slave bus
);
    localparam int N = 16;
    localparam int W = 24;
    localparam logic [W:0] ONE = (W+1)'(1);

    logic [1:0]     mode_reg;
    logic [W-1:0]   gmax_reg;
    logic           cap_active_reg;
    logic [3:0]     cap_row_reg;
    logic           cap_calc_reg;
    logic           s1_vld_reg;
    logic           s1_calc_reg;
    logic           s1_int4_reg;
    logic [3:0]     s1_row_reg;
    logic [4:0]     s1_shift_reg;
    logic [N*W-1:0] s1_data_reg;
    logic           out_any_reg;
    logic           valid_reg;
    logic           overrun_reg;
    logic [3:0]     row_reg;
    logic [4:0]     shift_reg;
    logic [8*N-1:0] data_reg;

    // Reserved mode 3 falls through to INT8 behaviour.
    logic int4_mode;
    logic vsq_mode;
    assign int4_mode = (mode_reg == 2'd1) || (mode_reg == 2'd2);
    assign vsq_mode  = (mode_reg == 2'd2);

    // A new tile may start when idle or in the cycle row 15 is captured.
    logic tile_free;
    logic tile_accept;
    logic tile_reject;
    assign tile_free   = !cap_active_reg || (cap_row_reg == 4'd15);
    assign tile_accept = bus.i_tile_start && !bus.i_mtrx_start && tile_free;
    assign tile_reject = bus.i_tile_start && !bus.i_mtrx_start && !tile_free;

    // Per-entry preprocessing and magnitude; |-2^23| = 2^23 fits unsigned 24.
    logic [N*W-1:0] ent_data;
    logic [W-1:0]   ent_abs [N];
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ent
            logic [W-1:0] raw;
            assign raw = bus.i_acc_data[W*gi +: W];
`ifdef PPU_RELU_EN
            assign ent_data[W*gi +: W] = raw[W-1] ? '0 : raw;
`else
            assign ent_data[W*gi +: W] = raw;
`endif
            assign ent_abs[gi] = ent_data[W*gi+W-1] ? (~ent_data[W*gi +: W] + 24'd1)
                                                    : ent_data[W*gi +: W];
        end
    endgenerate

    // Row maximum magnitude across all 16 entries.
    logic [W-1:0] rmax;
    always_comb begin
        rmax = '0;
        for (int i = 0; i < N; i++) begin
            if (ent_abs[i] > rmax) rmax = ent_abs[i];
        end
    end

    function automatic logic [4:0] bitlen(input logic [W-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) n = 5'(i + 1);
        end
        return n;
    endfunction

    // Scale exponent: bits of the reference magnitude beyond B-1.
    logic [W-1:0] shift_src;
    logic [4:0]   shift_bl;
    logic [4:0]   shift_base;
    logic [4:0]   shift_calc;
    always_comb begin
        shift_src  = vsq_mode ? rmax : gmax_reg;
        shift_bl   = bitlen(shift_src);
        shift_base = int4_mode ? 5'd3 : 5'd7;
        shift_calc = (shift_bl > shift_base) ? (shift_bl - shift_base) : 5'd0;
    end

    // Stage 2 datapath: round half up, arithmetic shift, saturate to B bits.
    logic [8*N-1:0] q_data;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_q
            logic signed [W:0] xs;
            logic signed [W:0] rnd;
            logic signed [W:0] sum;
            logic signed [W:0] shd;
            logic [7:0]        q;
            assign xs  = $signed({s1_data_reg[W*gi+W-1], s1_data_reg[W*gi +: W]});
            assign rnd = (s1_shift_reg == 5'd0) ? '0 : $signed(ONE << (s1_shift_reg - 5'd1));
            assign sum = xs + rnd;
            assign shd = sum >>> s1_shift_reg;
            // Clamp to the signed range of the active precision.
            always_comb begin
                q = shd[7:0];
                if (s1_int4_reg) begin
                    if (shd > 25'sd7)        q = 8'h07;
                    else if (shd < -25'sd8)  q = 8'hF8;
                end else begin
                    if (shd > 25'sd127)       q = 8'h7F;
                    else if (shd < -25'sd128) q = 8'h80;
                end
            end
            assign q_data[8*gi +: 8] = q;
        end
    endgenerate

    // Matrix state: latch mode and clear gmax on a new matrix; grow gmax in MAX passes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_reg <= 2'd0;
            gmax_reg <= '0;
        end else if (bus.i_mtrx_start) begin
            mode_reg <= bus.i_mode;
            gmax_reg <= '0;
        end else if (cap_active_reg && !cap_calc_reg && (rmax > gmax_reg)) begin
            gmax_reg <= rmax;
        end
    end

    // Capture counter: walks rows 0..15 after an accepted tile start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cap_active_reg <= 1'b0;
            cap_row_reg    <= 4'd0;
            cap_calc_reg   <= 1'b0;
        end else if (bus.i_mtrx_start) begin
            cap_active_reg <= 1'b0;
            cap_row_reg    <= 4'd0;
        end else if (tile_accept) begin
            cap_active_reg <= 1'b1;
            cap_row_reg    <= 4'd0;
            cap_calc_reg   <= bus.i_calc;
        end else if (cap_active_reg) begin
            if (cap_row_reg == 4'd15) cap_active_reg <= 1'b0;
            cap_row_reg <= cap_row_reg + 4'd1;
        end
    end

    // Stage 1 register: captured row with its shift; squashed by a new matrix.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld_reg   <= 1'b0;
            s1_calc_reg  <= 1'b0;
            s1_int4_reg  <= 1'b0;
            s1_row_reg   <= 4'd0;
            s1_shift_reg <= 5'd0;
            s1_data_reg  <= '0;
        end else begin
            s1_vld_reg <= cap_active_reg && !bus.i_mtrx_start;
            if (cap_active_reg) begin
                s1_calc_reg  <= cap_calc_reg;
                s1_int4_reg  <= int4_mode;
                s1_row_reg   <= cap_row_reg;
                s1_shift_reg <= shift_calc;
                s1_data_reg  <= ent_data;
            end
        end
    end

    // Stage 2 register: output row; data/row/shift only change on a valid row.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_any_reg <= 1'b0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            row_reg     <= 4'd0;
            shift_reg   <= 5'd0;
            data_reg    <= '0;
        end else begin
            out_any_reg <= s1_vld_reg && !bus.i_mtrx_start;
            valid_reg   <= s1_vld_reg && s1_calc_reg && !bus.i_mtrx_start;
            overrun_reg <= tile_reject;
            if (s1_vld_reg && s1_calc_reg && !bus.i_mtrx_start) begin
                row_reg   <= s1_row_reg;
                shift_reg <= s1_shift_reg;
                data_reg  <= q_data;
            end
        end
    end

    assign bus.o_valid   = valid_reg;
    assign bus.o_row     = row_reg;
    assign bus.o_data    = data_reg;
    assign bus.o_shift   = shift_reg;
    assign bus.o_overrun = overrun_reg;
    assign bus.o_busy    = cap_active_reg || s1_vld_reg || out_any_reg;
endmodule
